// File: rtl/fc_bias_relu_argmax_pkg.sv
// Shared definitions for the bias/ReLU/argmax stage behind the FC layer.
// This file holds the data width, the saturation limits and the FSM state encoding.
package fc_bias_relu_argmax_pkg;

    // Width of one vector element, bias word and activated result.
    localparam int DATA_W = 16;

    // Limits of the signed 16-bit range that a biased sum is clamped to.
    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    // Controller states. The encodings are fixed so that other layer stages can
    // decode them if they need to.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } fc_state_t;

endpackage : fc_bias_relu_argmax_pkg

// File: rtl/sat_add_relu16.sv
// Combinational signed 16-bit add, saturated to the 16-bit range, then ReLU.
// Other layer stages reuse this block for their own bias-plus-activation step.
module sat_add_relu16
    import fc_bias_relu_argmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] sat;

    // The 17-bit sign-extended sum cannot overflow. Bits 16 and 15 of that sum
    // differ only when the true result falls outside the 16-bit range.
    always_comb begin
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        sat = sum[DATA_W-1:0];
        if (!sum[DATA_W] && sum[DATA_W-1]) begin
            sat = SAT_MAX;
        end else if (sum[DATA_W] && !sum[DATA_W-1]) begin
            sat = SAT_MIN;
        end
        y = sat[DATA_W-1] ? '0 : sat;
    end

endmodule : sat_add_relu16

// File: rtl/fc_bias_relu_argmax.sv
// Stage that sits after the fully-connected layer. It takes one m-element vector
// and adds a bias to each element with saturation, then applies ReLU. It handles
// one element per cycle and tracks the maximum element and its index, which
// gives the classifier decision.
module fc_bias_relu_argmax
    import fc_bias_relu_argmax_pkg::*;
#(
    parameter int m     = 4,
    parameter int idx_w = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:m*DATA_W-1]   in_vector,
    input  logic [0:m*DATA_W-1]   bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:m*DATA_W-1]   out_vector,
    output logic [idx_w-1:0]      out_argmax,
    output logic [DATA_W-1:0]     out_max
);

    localparam logic [idx_w-1:0] LAST_IDX = idx_w'(m - 1);

    fc_state_t          state;
    logic [idx_w-1:0]   idx;
    logic [DATA_W-1:0]  in_elem   [m];
    logic [DATA_W-1:0]  bias_elem [m];
    logic [DATA_W-1:0]  cap_in    [m];
    logic [DATA_W-1:0]  cap_bias  [m];
    logic [DATA_W-1:0]  res       [m];
    logic [DATA_W-1:0]  max_q;
    logic [idx_w-1:0]   argmax_q;
    logic [DATA_W-1:0]  act;

    // Element 0 occupies the leftmost (lowest-numbered) bits of each packed bus.
    // These assigns unpack the inputs and pack the result array back out.
    for (genvar gi = 0; gi < m; gi++) begin : g_pack
        assign in_elem[gi]                       = in_vector[gi*DATA_W +: DATA_W];
        assign bias_elem[gi]                     = bias[gi*DATA_W +: DATA_W];
        assign out_vector[gi*DATA_W +: DATA_W]   = res[gi];
    end

    assign out_argmax = argmax_q;
    assign out_max    = max_q;

    // One shared bias/saturate/ReLU unit. It works on the element selected by the counter.
    sat_add_relu16 u_act (
        .a (cap_in[idx]),
        .b (cap_bias[idx]),
        .y (act)
    );

    // Controller: capture in IDLE, one element per cycle in PROC, and hold the results in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            max_q     <= '0;
            argmax_q  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < m; i++) begin
                cap_in[i]   <= '0;
                cap_bias[i] <= '0;
                res[i]      <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < m; i++) begin
                            cap_in[i]   <= in_elem[i];
                            cap_bias[i] <= bias_elem[i];
                        end
                        idx      <= '0;
                        max_q    <= '0;
                        argmax_q <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_PROC;
                    end
                end
                ST_PROC: begin
                    res[idx] <= act;
                    // The compare is strict, so a tie keeps the lower index.
                    // Element 0 always seeds the running maximum.
                    if ((idx == '0) || (act > max_q)) begin
                        max_q    <= act;
                        argmax_q <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + idx_w'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fc_bias_relu_argmax

// File: doc/fc_bias_relu_argmax.md
Name: fc_bias_relu_argmax

Overview:
- Stage directly downstream of the fully-connected layer. Consumes its m-element, 16-bit output vector.
- Per element: adds a per-neuron bias with saturation, then applies ReLU.
- Emits the activated vector plus the index and value of its maximum element (classifier decision).
- Processes one element per cycle through a small FSM, using valid/ready handshakes on both sides.

Parameters:
- m, 4: number of vector elements (FC output rows); must be >= 1.
- idx_w, 2: width of argmax index; must equal max(1, ceil(log2(m))).

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_vector/bias are valid.
- in_ready  output  1  block can accept a vector.
- in_vector  input  [0 : m*16-1]  FC result; element i = bits [i*16 : i*16+15], signed two's complement.
- bias  input  [0 : m*16-1]  per-element signed 16-bit bias, same packing as in_vector.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- out_vector  output  [0 : m*16-1]  activated vector, same packing as in_vector.
- out_argmax  output  [idx_w-1:0]  index of the maximum activated element.
- out_max  output  [15:0]  value of that element.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; all result and capture registers = 0; element counter = 0.
  - Outputs: in_ready=1, out_valid=0, out_vector=0, out_argmax=0, out_max=0.
  - Reset mid-operation discards any captured or partial data. First post-reset edge behaves as IDLE.
- States: IDLE, PROC, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready: capture in_vector and bias, set idx=0, clear max/argmax, go to PROC.
- PROC:
  - in_ready=0.
  - Each cycle processes element idx:
    - sum = sign-extended 17-bit in + bias.
    - Saturate to [-32768, 32767].
    - y = (sat < 0) ? 0 : sat.
    - Write y into result element idx.
  - Running max: if idx==0 or y > max (strict, unsigned compare is valid since y >= 0), set max=y and argmax=idx. Ties therefore keep the lowest index.
  - If idx==m-1, go to DONE; else idx++.
- DONE:
  - out_valid=1. out_vector/out_argmax/out_max are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid=0. Result registers keep their values until the next accept.
- Latency: accept on edge k → out_valid high after edge k+m. Throughput is one vector per m+2 cycles minimum; there is no overlap of accept and drain.
- in_valid while not in IDLE is ignored; upstream must hold the vector until in_ready.
- out_vector elements not yet processed in PROC are undefined to observers; only the value at out_valid is contractual.
- All-zero result (e.g. all inputs negative): out_max=0, out_argmax=0.
- m==1: PROC lasts exactly one cycle; out_argmax=0.

Decomposition:
- Shared include (fc_defs.vh) holds:
  - DATA_W=16, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
  - State encodings ST_IDLE=2'd0, ST_PROC=2'd1, ST_DONE=2'd2.
- One natural combinational sub-module, sat_add_relu16: (a, b) → 16-bit saturated-add-then-ReLU result. It is reused later by other layer stages.
- FSM, counter, and argmax tracking stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → immediately in_ready=1, out_valid=0, out_vector=0, out_argmax=0, out_max=0.
- Basic (m=4): in {0010, FFF0, 0030, 0005}, bias {0001, 0000, FFFF, 0000} → out_vector {0011, 0000, 002F, 0005}, out_argmax=2, out_max=002F. out_valid rises 4 edges after accept.
- Saturation/ReLU: in {7FF0, 8000, 0001, 0000}, bias {0020, FFFF, FFFF, 0000} → out_vector {7FFF, 0000, 0000, 0000}, argmax=0, max=7FFF.
- Ties/all-negative:
  - in all 0100, bias 0 → argmax=0, max=0100.
  - in all FF00, bias 0 → out_vector all 0, argmax=0, max=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, a second in_valid pulse is ignored. Raise out_ready → IDLE next edge, then the second vector is accepted and produces correct results.
- Reset mid-PROC: pulse rst_n low while idx=2 → out_valid never asserts for that vector, in_ready=1 after release. A new vector then processes with correct results and latency.
